// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - N-channel servo PWM bank with clamped targets and a shared frame counter
// Optional macro SERVO_SLEW_EN: limit per-frame change of each active pulse width to STEP cycles.
module servo_pwm_bank #(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = 24,
    parameter int PERIOD    = 2000000,
    parameter int MIN_PULSE = 100000,
    parameter int MAX_PULSE = 200000,
    parameter int STEP      = 1000
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          en_i,
    input  logic                                          wr_valid_i,
    output logic                                          wr_ready_o,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch_i,
    input  logic [CNT_W-1:0]                              wr_pulse_i,
    output logic                                          wr_err_o,
    output logic [NUM_CH-1:0]                             servo_out_o,
    output logic [NUM_CH-1:0]                             busy_o,
    output logic                                          frame_tick_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] CENTER   = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
`ifdef SERVO_SLEW_EN
    localparam logic [CNT_W-1:0] STEP_L   = CNT_W'(STEP);
`endif

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tgt_q [NUM_CH];
    logic [CNT_W-1:0]  tgt_d [NUM_CH];
    logic [CNT_W-1:0]  cur_q [NUM_CH];
    logic [CNT_W-1:0]  cur_d [NUM_CH];
    logic [NUM_CH-1:0] servo_q, servo_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic              wr_ready_q, wr_ready_d;
    logic              wr_err_q, wr_err_d;
    logic              tick_q;
    logic              boundary;
    logic              accept;
    logic              ch_ok;
    logic [CNT_W-1:0]  wr_clamped;

    always_comb begin
        boundary = en_i && (cnt_q == LAST);
        accept   = wr_valid_i && wr_ready_q;
        ch_ok    = ({1'b0, wr_ch_i} < NUM_CH_L);

        if (wr_pulse_i < MIN_L) begin
            wr_clamped = MIN_L;
        end else if (wr_pulse_i > MAX_L) begin
            wr_clamped = MAX_L;
        end else begin
            wr_clamped = wr_pulse_i;
        end

        if (!en_i || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Ready is withheld for the cycle the counter will sit on the frame boundary,
        // so a target write can never race the cur update.
        wr_ready_d = (cnt_d != LAST);
        wr_err_d   = accept && !ch_ok;

        for (int i = 0; i < NUM_CH; i++) begin
            tgt_d[i]   = tgt_q[i];
            cur_d[i]   = cur_q[i];
            servo_d[i] = en_i && (cnt_q < cur_q[i]);
            busy_d[i]  = (cur_q[i] != tgt_q[i]);

            if (accept && (wr_ch_i == CH_W'(i))) begin
                tgt_d[i] = wr_clamped;
            end

            if (boundary) begin
`ifdef SERVO_SLEW_EN
                if (cur_q[i] < tgt_q[i]) begin
                    cur_d[i] = ((tgt_q[i] - cur_q[i]) > STEP_L) ? (cur_q[i] + STEP_L) : tgt_q[i];
                end else if (cur_q[i] > tgt_q[i]) begin
                    cur_d[i] = ((cur_q[i] - tgt_q[i]) > STEP_L) ? (cur_q[i] - STEP_L) : tgt_q[i];
                end
`else
                cur_d[i] = tgt_q[i];
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            servo_q    <= '0;
            busy_q     <= '0;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            tick_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= CENTER;
                cur_q[i] <= CENTER;
            end
        end else begin
            cnt_q      <= cnt_d;
            servo_q    <= servo_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q   <= wr_err_d;
            tick_q     <= boundary;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign wr_ready_o   = wr_ready_q;
    assign wr_err_o     = wr_err_q;
    assign servo_out_o  = servo_q;
    assign busy_o       = busy_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb/tb_servo_pwm_bank.sv - self-checking bench for servo_pwm_bank against a frame-level reference model
module tb_servo_pwm_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 24;
    localparam int PERIOD = 100;
    localparam int MIN_P  = 10;
    localparam int MAX_P  = 20;
    localparam int STEP   = 2;
    localparam int CENTER = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              wr_valid;
    logic [1:0]        wr_ch;
    logic [CNT_W-1:0]  wr_pulse;
    logic              wr_ready;
    logic              wr_err;
    logic [NUM_CH-1:0] servo_out;
    logic [NUM_CH-1:0] busy;
    logic              frame_tick;

    int total = 0;
    int bad   = 0;

    int m_cnt = 0;
    int m_tgt [NUM_CH];
    int m_cur [NUM_CH];
    logic [NUM_CH-1:0] exp_servo, exp_busy;
    logic              exp_tick, exp_err;

    int meas_w [NUM_CH];
    int exp_w  [NUM_CH];
    int meas_err, exp_err_cnt;
    logic [NUM_CH-1:0] first_hi, busy_mid, exp_busy_mid;

    servo_pwm_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD),
        .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P), .STEP(STEP)
    ) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_ch_i(wr_ch),
        .wr_pulse_i(wr_pulse), .wr_err_o(wr_err), .servo_out_o(servo_out),
        .busy_o(busy), .frame_tick_o(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int p);
        if (p < MIN_P) return MIN_P;
        if (p > MAX_P) return MAX_P;
        return p;
    endfunction

    // Advance one clock: the model applies the rules for this edge, then the DUT is sampled 1 ns later.
    task automatic step();
        bit acc;
        acc      = wr_valid && wr_ready && !reset;
        exp_tick = !reset && en && (m_cnt == PERIOD - 1);
        exp_err  = acc && (int'(wr_ch) >= NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            exp_servo[k] = !reset && en && (m_cnt < m_cur[k]);
            exp_busy[k]  = !reset && (m_cur[k] != m_tgt[k]);
        end
        if (reset) begin
            m_cnt = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_tgt[k] = CENTER;
                m_cur[k] = CENTER;
            end
        end else begin
            if (!en) begin
                m_cnt = 0;
            end else if (m_cnt == PERIOD - 1) begin
                m_cnt = 0;
                for (int k = 0; k < NUM_CH; k++) begin
`ifdef SERVO_SLEW_EN
                    if (m_tgt[k] > m_cur[k] + STEP) m_cur[k] += STEP;
                    else if (m_tgt[k] < m_cur[k] - STEP) m_cur[k] -= STEP;
                    else m_cur[k] = m_tgt[k];
`else
                    m_cur[k] = m_tgt[k];
`endif
                end
            end else begin
                m_cnt++;
            end
            if (acc && int'(wr_ch) < NUM_CH) m_tgt[wr_ch] = clamp(int'(wr_pulse));
        end
        @(posedge clk);
        #1;
        if (acc) wr_valid = 1'b0;
    endtask

    // Align to a frame start, optionally issue one write at cycle drive_at, and measure one full frame.
    task automatic measure_frame(input int drive_at, input int ch, input int pulse);
        int guard;
        guard = 0;
        while (m_cnt != 0 && guard < 2 * PERIOD) begin
            step();
            guard++;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            exp_w[k]  = m_cur[k];
            meas_w[k] = 0;
        end
        meas_err    = 0;
        exp_err_cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == drive_at) begin
                wr_valid = 1'b1;
                wr_ch    = 2'(ch);
                wr_pulse = CNT_W'(pulse);
            end
            step();
            for (int k = 0; k < NUM_CH; k++) meas_w[k] += int'(servo_out[k]);
            meas_err    += int'(wr_err);
            exp_err_cnt += int'(exp_err);
            if (i == 0) first_hi = servo_out;
            if (i == PERIOD / 2) begin
                busy_mid     = busy;
                exp_busy_mid = exp_busy;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_pulse = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (servo_out !== 3'b000 || wr_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: servo_out=%b wr_ready=%b required 000/0", servo_out, wr_ready);
            end
        end
        total++;
        if (busy !== 3'b000 || wr_err !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b wr_err=%b tick=%b required 000/0/0", busy, wr_err, frame_tick);
        end
        reset = 1'b0;
        en    = 1'b1;
        for (int f = 0; f < 2; f++) begin
            measure_frame(-1, 0, 0);
            total++;
            if (first_hi !== 3'b111) begin
                bad++;
                $display("FAIL reset_rise_aligned: first=%b required 111", first_hi);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                total++;
                if (meas_w[k] !== CENTER) begin
                    bad++;
                    $display("FAIL reset_width ch%0d: got %0d required %0d", k, meas_w[k], CENTER);
                end
            end
        end
    endtask

    task automatic test_write_slew();
        int seq_w [3];
        logic seq_b [3];
`ifdef SERVO_SLEW_EN
        seq_w = '{17, 19, 19};
        seq_b = '{1'b1, 1'b0, 1'b0};
`else
        seq_w = '{19, 19, 19};
        seq_b = '{1'b0, 1'b0, 1'b0};
`endif
        measure_frame(30, 1, 19);
        total++;
        if (meas_w[1] !== CENTER || busy_mid[1] !== 1'b1) begin
            bad++;
            $display("FAIL write_frame0: width=%0d busy=%b required %0d/1", meas_w[1], busy_mid[1], CENTER);
        end
        for (int f = 0; f < 3; f++) begin
            measure_frame(-1, 0, 0);
            total++;
            if (meas_w[1] !== seq_w[f] || busy_mid[1] !== seq_b[f]) begin
                bad++;
                $display("FAIL write_frame%0d: width=%0d busy=%b required %0d/%b",
                         f + 1, meas_w[1], busy_mid[1], seq_w[f], seq_b[f]);
            end
        end
    endtask

    task automatic test_clamp();
        int req [2];
        int lim [2];
        req = '{5, 30};
        lim = '{MIN_P, MAX_P};
        for (int r = 0; r < 2; r++) begin
            measure_frame(20, 0, req[r]);
            for (int f = 0; f < 6; f++) begin
                measure_frame(-1, 0, 0);
                total++;
                if (meas_w[0] !== exp_w[0] || meas_w[0] < MIN_P || meas_w[0] > MAX_P) begin
                    bad++;
                    $display("FAIL clamp_width req=%0d frame%0d: got %0d required %0d", req[r], f, meas_w[0], exp_w[0]);
                end
            end
            total++;
            if (meas_w[0] !== lim[r]) begin
                bad++;
                $display("FAIL clamp_final req=%0d: got %0d required %0d", req[r], meas_w[0], lim[r]);
            end
        end
    endtask

    task automatic test_invalid();
        int err_cnt, nines, rdy_bad;
        err_cnt = 0; nines = 0; rdy_bad = 0;
        wr_valid = 1'b1; wr_ch = 2'd3; wr_pulse = CNT_W'(12);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            err_cnt += int'(wr_err);
            if (m_cnt == PERIOD - 1) begin
                nines++;
                if (wr_ready !== 1'b0) rdy_bad++;
            end
        end
        total++;
        if (err_cnt !== 1 || wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL invalid_err: err cycles=%0d valid=%b required 1/0", err_cnt, wr_valid);
        end
        total++;
        if (rdy_bad !== 0 || nines !== 2) begin
            bad++;
            $display("FAIL ready_boundary: ready high on %0d of %0d boundary cycles required 0 of 2", rdy_bad, nines);
        end
        measure_frame(-1, 0, 0);
        total++;
        if (meas_w[0] !== 20 || meas_w[1] !== 19 || meas_w[2] !== 15) begin
            bad++;
            $display("FAIL invalid_no_change: widths %0d/%0d/%0d required 20/19/15", meas_w[0], meas_w[1], meas_w[2]);
        end
    endtask

    task automatic test_en_drop();
        int guard, quiet_bad, tick_at, w2;
        guard = 0;
        while (m_cnt != 5 && guard < 2 * PERIOD) begin
            step();
            guard++;
        end
        total++;
        if (servo_out[2] !== 1'b1) begin
            bad++;
            $display("FAIL en_pre_drop: ch2=%b required 1", servo_out[2]);
        end
        en = 1'b0;
        step();
        total++;
        if (servo_out !== 3'b000) begin
            bad++;
            $display("FAIL en_drop_next: servo_out=%b required 000", servo_out);
        end
        quiet_bad = 0;
        for (int i = 0; i < 39; i++) begin
            step();
            if (servo_out !== 3'b000 || frame_tick !== 1'b0 || wr_ready !== 1'b1) quiet_bad++;
        end
        total++;
        if (quiet_bad !== 0) begin
            bad++;
            $display("FAIL en_low_quiet: %0d bad cycles required 0", quiet_bad);
        end
        en = 1'b1;
        tick_at = -1; w2 = 0;
        for (int i = 1; i <= PERIOD; i++) begin
            step();
            if (i == 1) first_hi = servo_out;
            w2 += int'(servo_out[2]);
            if (frame_tick === 1'b1 && tick_at < 0) tick_at = i;
        end
        total++;
        if (first_hi !== 3'b111 || w2 !== 15) begin
            bad++;
            $display("FAIL en_reraise_pulse: first=%b ch2 width=%0d required 111/15", first_hi, w2);
        end
        total++;
        if (tick_at !== PERIOD) begin
            bad++;
            $display("FAIL en_reraise_frame: first tick at %0d required %0d", tick_at, PERIOD);
        end
    endtask

    task automatic test_reset_mid();
        measure_frame(10, 0, 12);
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        total++;
        if (servo_out !== 3'b000 || busy !== 3'b000 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: servo=%b busy=%b ready=%b required 000/000/0", servo_out, busy, wr_ready);
        end
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            measure_frame(-1, 0, 0);
            total++;
            if (meas_w[0] !== CENTER || meas_w[1] !== CENTER || meas_w[2] !== CENTER) begin
                bad++;
                $display("FAIL reset_mid_width f%0d: %0d/%0d/%0d required 15/15/15", f, meas_w[0], meas_w[1], meas_w[2]);
            end
        end
    endtask

    task automatic test_random();
        int ch, p, at;
        for (int n = 0; n < 8; n++) begin
            ch = int'($urandom_range(0, 3));
            p  = int'($urandom_range(0, 40));
            at = int'($urandom_range(0, 98));
            measure_frame(at, ch, p);
            total++;
            if (meas_err !== exp_err_cnt || busy_mid !== exp_busy_mid) begin
                bad++;
                $display("FAIL rand_flags n%0d ch=%0d p=%0d: err=%0d busy=%b required %0d/%b",
                         n, ch, p, meas_err, busy_mid, exp_err_cnt, exp_busy_mid);
            end
            for (int f = 0; f < 2; f++) begin
                measure_frame(-1, 0, 0);
                for (int k = 0; k < NUM_CH; k++) begin
                    total++;
                    if (meas_w[k] !== exp_w[k]) begin
                        bad++;
                        $display("FAIL rand_width n%0d f%0d ch%0d: got %0d required %0d", n, f, k, meas_w[k], exp_w[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_slew();
        test_clamp();
        test_invalid();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
